// File: rtl/formula_2_pipe_fifos_bp.sv
// formula_2_pipe_fifos_bp: pipelined isqrt(a + isqrt(b + isqrt(c))) with credit-gated output FIFO.
// Define FORMULA_2_PIPE_SAT_ADD_EN to make both adds saturate instead of wrap.
module formula_2_pipe_fifos_bp_isqrt #(
  parameter int STAGES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld_i,
  input  logic [31:0] x_i,
  output logic        y_vld_o,
  output logic [31:0] y_o
);
  logic        v  [0:16];
  logic [31:0] rs [0:16];
  logic [31:0] op [0:15];
  assign v[0]    = x_vld_i;
  assign rs[0]   = '0;
  assign op[0]   = x_i;
  assign y_vld_o = v[16];
  assign y_o     = rs[16];
  // 16 digit iterations; a register follows iteration i whenever floor(i*STAGES/16) steps up
  for (genvar i = 0; i < 16; i++) begin : g_it
    localparam logic [31:0] ONE = 32'h4000_0000 >> (2 * i);
    localparam bit REG = ((i + 1) * STAGES / 16) > (i * STAGES / 16);
    logic        ge;
    logic [31:0] rs_n;
    assign ge   = op[i] >= rs[i] + ONE;
    assign rs_n = ge ? (rs[i] >> 1) + ONE : rs[i] >> 1;
    if (REG) begin : g_r
      logic        v_q;
      logic [31:0] rs_q;
      always_ff @(posedge clk) begin
        v_q  <= rst ? 1'b0 : v[i];
        rs_q <= rs_n;
      end
      assign v[i+1]  = v_q;
      assign rs[i+1] = rs_q;
    end else begin : g_c
      assign v[i+1]  = v[i];
      assign rs[i+1] = rs_n;
    end
    if (i < 15) begin : g_op
      logic [31:0] op_n;
      assign op_n = ge ? op[i] - (rs[i] + ONE) : op[i];
      if (REG) begin : g_r
        logic [31:0] op_q;
        always_ff @(posedge clk) op_q <= op_n;
        assign op[i+1] = op_q;
      end else begin : g_c
        assign op[i+1] = op_n;
      end
    end
  end
endmodule

module formula_2_pipe_fifos_bp_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] cnt_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;
  assign do_pop  = pop_i && cnt_q != '0;
  assign do_push = push_i && (cnt_q != CW'(DEPTH) || do_pop);
  assign dout_o  = mem_q[rp_q];
  assign cnt_o   = cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q == AW'(DEPTH - 1) ? '0 : wp_q + 1'b1;
      if (do_pop) rp_q <= rp_q == AW'(DEPTH - 1) ? '0 : rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wp_q] <= din_i;
  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push_i && cnt_q == CW'(DEPTH) && !pop_i));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop_i && cnt_q == '0));
endmodule

module formula_2_pipe_fifos_bp #(
  parameter int ISQRT_STAGES = 4,
  parameter int OUT_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arg_vld,
  output logic        arg_rdy,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic        res_vld,
  input  logic        res_rdy,
  output logic [31:0] res
);
  localparam int CW  = $clog2(OUT_DEPTH + 1);
  localparam int BD  = ISQRT_STAGES + 2;
  localparam int AD  = 2 * ISQRT_STAGES + 4;
  localparam int BCW = $clog2(BD + 1);
  localparam int ACW = $clog2(AD + 1);
  function automatic logic [31:0] add32(input logic [31:0] x, input logic [31:0] y);
`ifdef FORMULA_2_PIPE_SAT_ADD_EN
    logic [32:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
    return x + y;
`endif
  endfunction
  logic           acc, out_pop, c_vld_q, s1_vld_q, s2_vld_q, y1_vld, y2_vld, y3_vld;
  logic [31:0]    c_q, s1_q, s2_q, y1, y2, y3, b_dly, a_dly, out_dout;
  logic [CW-1:0]  inflight_q, inflight_d, out_cnt;
  logic [CW:0]    credit;
  logic [BCW-1:0] b_cnt;
  logic [ACW-1:0] a_cnt;
  // every accepted set owns an output slot until it is popped, so the output FIFO cannot overflow
  assign credit     = {1'b0, inflight_q} + {1'b0, out_cnt};
  assign arg_rdy    = credit < (CW + 1)'(OUT_DEPTH);
  assign acc        = arg_vld && arg_rdy;
  assign res_vld    = out_cnt != '0;
  assign out_pop    = res_vld && res_rdy;
  assign res        = res_vld ? out_dout : '0;
  assign inflight_d = inflight_q + CW'(acc) - CW'(y3_vld);
  always_ff @(posedge clk) begin
    c_vld_q    <= !rst && acc;
    s1_vld_q   <= !rst && y1_vld && b_cnt != '0;
    s2_vld_q   <= !rst && y2_vld && a_cnt != '0;
    inflight_q <= rst ? '0 : inflight_d;
    c_q        <= c;
    s1_q       <= add32(b_dly, y1);
    s2_q       <= add32(a_dly, y2);
  end
  formula_2_pipe_fifos_bp_isqrt #(.STAGES(ISQRT_STAGES)) u_sq1 (
    .clk(clk), .rst(rst), .x_vld_i(c_vld_q), .x_i(c_q), .y_vld_o(y1_vld), .y_o(y1));
  formula_2_pipe_fifos_bp_isqrt #(.STAGES(ISQRT_STAGES)) u_sq2 (
    .clk(clk), .rst(rst), .x_vld_i(s1_vld_q), .x_i(s1_q), .y_vld_o(y2_vld), .y_o(y2));
  formula_2_pipe_fifos_bp_isqrt #(.STAGES(ISQRT_STAGES)) u_sq3 (
    .clk(clk), .rst(rst), .x_vld_i(s2_vld_q), .x_i(s2_q), .y_vld_o(y3_vld), .y_o(y3));
  formula_2_pipe_fifos_bp_fifo #(.W(32), .DEPTH(BD)) u_b_fifo (
    .clk(clk), .rst(rst), .push_i(acc), .din_i(b), .pop_i(y1_vld), .dout_o(b_dly), .cnt_o(b_cnt));
  formula_2_pipe_fifos_bp_fifo #(.W(32), .DEPTH(AD)) u_a_fifo (
    .clk(clk), .rst(rst), .push_i(acc), .din_i(a), .pop_i(y2_vld), .dout_o(a_dly), .cnt_o(a_cnt));
  formula_2_pipe_fifos_bp_fifo #(.W(32), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk(clk), .rst(rst), .push_i(y3_vld), .din_i(y3), .pop_i(out_pop), .dout_o(out_dout), .cnt_o(out_cnt));
endmodule

// File: tb/tb_formula_2_pipe_fifos_bp.sv
// tb_formula_2_pipe_fifos_bp: directed and random checks against a queue-based reference model.
// OUT_DEPTH is 32 here so that credit covers a full LAT window of back-to-back sets.
module tb_formula_2_pipe_fifos_bp;
  localparam int ISQ = 4, DEPTH = 32, LAT = 3 * ISQ + 3;
  logic clk = 0, rst = 1, arg_vld = 0, res_rdy = 1, arg_rdy, res_vld;
  logic [31:0] a = 0, b = 0, c = 0, res;
  int total = 0, bad = 0, cyc = 0, n_acc = 0;
  typedef struct { logic [31:0] v; int t; } ent_t;
  ent_t sb[$];
  bit hold = 0;
  logic [31:0] hold_res = 0;

  formula_2_pipe_fifos_bp #(.ISQRT_STAGES(ISQ), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy), .a(a), .b(b), .c(c),
    .res_vld(res_vld), .res_rdy(res_rdy), .res(res));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] m_isqrt(input logic [31:0] x);
    longint unsigned r = 0, t;
    for (int k = 15; k >= 0; k--) begin
      t = r | (64'd1 << k);
      if (t * t <= 64'(x)) r = t;
    end
    return 32'(r);
  endfunction

  function automatic logic [31:0] m_add(input logic [31:0] x, input logic [31:0] y);
    longint unsigned s = 64'(x) + 64'(y);
`ifdef FORMULA_2_PIPE_SAT_ADD_EN
    return s > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : 32'(s);
`else
    return 32'(s);
`endif
  endfunction

  function automatic logic [31:0] m_f(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return m_isqrt(m_add(x, m_isqrt(m_add(y, m_isqrt(z)))));
  endfunction

  // Outstanding sets = queue length; a set reaches the output FIFO LAT edges after its accept edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      hold = 0;
    end else begin
      check("arg_rdy", 32'(arg_rdy), 32'(sb.size() < DEPTH));
      check("res_vld", 32'(res_vld), 32'(sb.size() > 0 && cyc >= sb[0].t + LAT));
      if (hold) check("res_hold", res, hold_res);
      if (res_vld && res_rdy && sb.size() > 0) check("res", res, sb.pop_front().v);
      hold = res_vld && !res_rdy;
      hold_res = res;
      if (arg_vld && arg_rdy) begin
        sb.push_back('{m_f(a, b, c), cyc + 1});
        n_acc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] ic, output int waits);
    bit ok;
    arg_vld = 1; a = ia; b = ib; c = ic; waits = 0;
    do begin
      @(negedge clk);
      ok = arg_rdy;
      if (!ok) waits++;
      step();
    end while (!ok && waits < 500);
    if (!ok) check("send_timeout", 0, 1);
    arg_vld = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 0);
    step();
  endtask

  task automatic single(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] ic,
                        input logic [31:0] exp, input string name);
    int w, t0, lat = -1;
    send(ia, ib, ic, w);
    t0 = cyc;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (res_vld) begin
        lat = cyc - t0;
        break;
      end
    end
    check({name, "_lat"}, lat, 15);
    check({name, "_res"}, res, exp);
    step();
    drain();
  endtask

  initial begin
    int w, wsum, base, cnt;
    check("pin_5_12_16", m_f(5, 12, 16), 3);
    check("pin_isqrt99", m_isqrt(99), 9);
`ifdef FORMULA_2_PIPE_SAT_ADD_EN
    check("pin_corner", m_f(0, 32'hFFFF_FFFF, 4), 255);
    check("pin_max", m_f('1, '1, '1), 65535);
`else
    check("pin_corner", m_f(0, 32'hFFFF_FFFF, 4), 1);
    check("pin_max", m_f('1, '1, '1), 15);
`endif
    repeat (3) step();
    rst = 0;
    @(negedge clk);
    check("reset_res_vld", 32'(res_vld), 0);
    check("reset_arg_rdy", 32'(arg_rdy), 1);
    check("reset_res", res, 0);
    step();
    single(5, 12, 16, 3, "single");
    wsum = 0;
    for (int i = 0; i < 200; i++) begin
      send($urandom, $urandom, $urandom, w);
      wsum += w;
    end
    check("b2b_waits", wsum, 0);
    drain();
    res_rdy = 0;
    base = n_acc;
    for (int i = 0; i < 60; i++) begin
      arg_vld = 1; a = $urandom; b = $urandom; c = $urandom;
      step();
    end
    check("stall_accepts", n_acc - base, DEPTH);
    @(negedge clk);
    check("stall_arg_rdy", 32'(arg_rdy), 0);
    step();
    res_rdy = 1;
    base = n_acc;
    for (int i = 0; i < 60; i++) begin
      a = $urandom; b = $urandom; c = $urandom;
      step();
    end
    arg_vld = 0;
    check("resume", 32'(n_acc - base > 40), 1);
    drain();
`ifdef FORMULA_2_PIPE_SAT_ADD_EN
    single(0, 32'hFFFF_FFFF, 4, 255, "corner");
`else
    single(0, 32'hFFFF_FFFF, 4, 1, "corner");
`endif
    res_rdy = 0;
    for (int i = 0; i < 3; i++) send($urandom, $urandom, $urandom, w);
    repeat (LAT + 3) step();
    for (int i = 0; i < 6; i++) send($urandom, $urandom, $urandom, w);
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    check("midrst_res_vld", 32'(res_vld), 0);
    check("midrst_arg_rdy", 32'(arg_rdy), 1);
    check("midrst_res", res, 0);
    res_rdy = 1;
    cnt = 0;
    for (int i = 0; i < 3 * LAT; i++) begin
      @(negedge clk);
      if (res_vld) cnt++;
    end
    check("midrst_stale", cnt, 0);
    step();
    single(20, 24, 1, 5, "post_rst");
    base = n_acc;
    for (int n = 0; n < 20000 && n_acc - base < 1000; n++) begin
      arg_vld = 1'($urandom_range(1, 0));
      res_rdy = 1'($urandom_range(1, 0));
      a = $urandom; b = $urandom; c = $urandom;
      step();
    end
    arg_vld = 0;
    res_rdy = 1;
    check("rand_accepts", 32'(n_acc - base >= 1000), 1);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad + 1);
    $fatal(1, "watchdog");
  end
endmodule
